// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding, default
// byte width and the grant-index width helper.
package uart_tx_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Pointer-based round-robin picker: searches req starting at ptr, wrapping
// NUM_REQ-1 -> 0, and returns the first set index plus an any-valid flag.
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk the requesters in search order and keep the first hit.
    always_comb begin
        idx       = {IDX_W{1'b0}};
        any_valid = 1'b0;
        sum       = {(IDX_W+1){1'b0}};
        cand      = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum = sum;
            end
            cand = sum[IDX_W-1:0];
            if (!any_valid && req[cand]) begin
                idx       = cand;
                any_valid = 1'b1;
            end else begin
                idx       = idx;
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// requesters. Latches the winner's byte and parity enable, issues a single
// Data_valid pulse, follows tx_busy to find the end of the frame and acks.
// Optional build macro UART_ARB_PRIO0_EN: requester 0 gets strict priority,
// the rest round-robin among themselves.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int  BUSY_WAIT_MAX = 4,
    localparam int IDX_W         = idx_width(NUM_REQ),
    localparam int CNT_W         = idx_width(BUSY_WAIT_MAX)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_par_en,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          req_err,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          arb_busy,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_par_en,
    input  logic                          tx_busy
);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  wait_cnt;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    pick_mask;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [IDX_W-1:0]      winner;
    logic                  win_any;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_par;
    logic [NUM_REQ-1:0]    ack_vec;
    logic [IDX_W-1:0]      ptr_next;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (pick_mask),
        .ptr       (rr_ptr),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // Eligibility, winner selection and the winner's payload.
    always_comb begin
        // A requester being acked this cycle may still hold req_valid; mask it
        // so it cannot be granted a second frame.
        eligible = req_valid & ~req_ack;
`ifdef UART_ARB_PRIO0_EN
        pick_mask = eligible & ~{{(NUM_REQ-1){1'b0}}, 1'b1};
        if (eligible[0]) begin
            winner  = {IDX_W{1'b0}};
            win_any = 1'b1;
        end else begin
            winner  = pick_idx;
            win_any = pick_any;
        end
`else
        pick_mask = eligible;
        winner    = pick_idx;
        win_any   = pick_any;
`endif
        win_data = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                win_data = win_data;
            end
        end
        win_par = req_par_en[winner];
        ack_vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        if (grant_id == IDX_W'(NUM_REQ-1)) begin
            ptr_next = {IDX_W{1'b0}};
        end else begin
            ptr_next = grant_id + IDX_W'(1);
        end
    end

    // Arbiter FSM with registered outputs toward the requesters and the TX.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= {IDX_W{1'b0}};
            wait_cnt      <= {CNT_W{1'b0}};
            req_ack       <= {NUM_REQ{1'b0}};
            req_err       <= 1'b0;
            grant_id      <= {IDX_W{1'b0}};
            arb_busy      <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= {DATA_WIDTH{1'b0}};
            tx_par_en     <= 1'b0;
        end else begin
            req_ack       <= {NUM_REQ{1'b0}};
            req_err       <= 1'b0;
            tx_data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        state         <= ST_ISSUE;
                        grant_id      <= winner;
                        tx_p_data     <= win_data;
                        tx_par_en     <= win_par;
                        tx_data_valid <= 1'b1;
                        arb_busy      <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= {CNT_W{1'b0}};
                    state    <= ST_WAIT_BUSY;
                    arb_busy <= 1'b1;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (wait_cnt == CNT_W'(BUSY_WAIT_MAX-1)) begin
                        // TX never started: fail the frame, keep the pointer
                        // so the same requester is first in line again.
                        req_ack  <= ack_vec;
                        req_err  <= 1'b1;
                        wait_cnt <= {CNT_W{1'b0}};
                        state    <= ST_IDLE;
                        arb_busy <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        req_ack  <= ack_vec;
                        rr_ptr   <= ptr_next;
                        state    <= ST_IDLE;
                        arb_busy <= 1'b0;
                    end else begin
                        state <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter. The bench plays the
// UART TX (busy after a random delay for a random length, or never) and
// predicts grants and ack timing from a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DW       = 8;
    localparam int BWM      = 4;
    localparam int N_FRAMES = 80;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [31:0]   req_data;
    logic [3:0]    req_par_en;
    logic [3:0]    req_ack;
    logic          req_err;
    logic [1:0]    grant_id;
    logic          arb_busy;
    logic          tx_data_valid;
    logic [7:0]    tx_p_data;
    logic          tx_par_en;
    logic          tx_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_WIDTH    (DW),
        .BUSY_WAIT_MAX (BWM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_par_en    (req_par_en),
        .req_ack       (req_ack),
        .req_err       (req_err),
        .grant_id      (grant_id),
        .arb_busy      (arb_busy),
        .tx_data_valid (tx_data_valid),
        .tx_p_data     (tx_p_data),
        .tx_par_en     (tx_par_en),
        .tx_busy       (tx_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance exactly one clock, landing on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference arbitration: first eligible requester at or after ptr,
    // wrapping; with the priority build, requester 0 always goes first.
    function automatic int model_pick(input logic [3:0] e_in, input int p);
        logic [3:0] e;
        e = e_in;
`ifdef UART_ARB_PRIO0_EN
        if (e[0]) return 0;
        e[0] = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (e[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        end
        return -1;
    endfunction

    initial begin
        int         ptr;
        logic [3:0] mask;
        logic [3:0] hold_bit;
        bit         hold_drop;
        logic [3:0] elig;
        logic [3:0] hb;
        int         w;
        logic [7:0] exp_data;
        logic       exp_par;
        int         mode;
        int         d;
        int         len;
        int         ack_off;
        int         rst_off;
        int         r;
        bit         reset_hit;

        rst        = 1'b1;
        req_valid  = 4'd0;
        req_data   = 32'd0;
        req_par_en = 4'd0;
        tx_busy    = 1'b0;
        ptr        = 0;
        mask       = 4'd0;
        hold_bit   = 4'd0;
        hold_drop  = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_ack",   32'(req_ack),       32'd0);
        check_eq("rst_err",   32'(req_err),       32'd0);
        check_eq("rst_grant", 32'(grant_id),      32'd0);
        check_eq("rst_busy",  32'(arb_busy),      32'd0);
        check_eq("rst_dv",    32'(tx_data_valid), 32'd0);
        check_eq("rst_pdata", 32'(tx_p_data),     32'd0);
        check_eq("rst_par",   32'(tx_par_en),     32'd0);
        rst = 1'b0;

        // Single requester 2, byte A5 with parity.
        req_valid  = 4'b0100;
        req_data   = 32'h00A5_0000;
        req_par_en = 4'b0100;

        for (int f = 0; f < N_FRAMES; f++) begin
            // Idle until an eligible request exists; nothing may be issued meanwhile.
            while ((req_valid & ~mask) == 4'd0) begin
                next_cycle();
                check_eq("idle_dv",   32'(tx_data_valid), 32'd0);
                check_eq("idle_busy", 32'(arb_busy),      32'd0);
                mask = 4'd0;
                if (hold_drop) begin
                    req_valid = req_valid & ~hold_bit;
                    hold_drop = 1'b0;
                end else if (req_valid == 4'd0) begin
                    req_valid = 4'($urandom_range(1, 15));
                end
            end

            elig     = req_valid & ~mask;
            w        = model_pick(elig, ptr);
            exp_data = req_data[w*8 +: 8];
            exp_par  = req_par_en[w];
            hb       = 4'(1 << w);

            next_cycle();
            check_eq("issue_dv",    32'(tx_data_valid), 32'd1);
            check_eq("issue_grant", 32'(grant_id),      32'(w));
            check_eq("issue_data",  32'(tx_p_data),     32'(exp_data));
            check_eq("issue_par",   32'(tx_par_en),     32'(exp_par));
            check_eq("issue_busy",  32'(arb_busy),      32'd1);
            mask = 4'd0;

            // Changes after the grant must not reach the TX.
            req_data   = $urandom;
            req_par_en = 4'($urandom);

            if (f == 0) begin
                mode = 0;
            end else if (f == 6) begin
                mode = 1;
            end else if (f == 9) begin
                mode = 2;
            end else if (f >= 10) begin
                r    = int'($urandom_range(0, 11));
                mode = (r < 2) ? 1 : ((r == 2) ? 2 : 0);
            end else begin
                mode = 0;
            end
            d   = (f == 0) ? 2  : int'($urandom_range(1, BWM));
            len = (f == 0) ? 11 : int'($urandom_range(2, 10));
            ack_off = (mode == 1) ? BWM + 1 : d + len + 1;
            rst_off = d + int'($urandom_range(1, len));
            reset_hit = 1'b0;

            for (int k = 1; k <= ack_off; k++) begin
                next_cycle();
                if (k < ack_off) begin
                    check_eq("early_ack", 32'(req_ack),   32'd0);
                    check_eq("hold_data", 32'(tx_p_data), 32'(exp_data));
                    if (k == 1) check_eq("dv_pulse", 32'(tx_data_valid), 32'd0);
                    if (mode == 2 && k == rst_off) begin
                        rst       = 1'b1;
                        tx_busy   = 1'b0;
                        req_valid = 4'd0;
                        next_cycle();
                        check_eq("mrst_ack",   32'(req_ack),       32'd0);
                        check_eq("mrst_err",   32'(req_err),       32'd0);
                        check_eq("mrst_busy",  32'(arb_busy),      32'd0);
                        check_eq("mrst_grant", 32'(grant_id),      32'd0);
                        check_eq("mrst_dv",    32'(tx_data_valid), 32'd0);
                        check_eq("mrst_pdata", 32'(tx_p_data),     32'd0);
                        check_eq("mrst_par",   32'(tx_par_en),     32'd0);
                        rst       = 1'b0;
                        ptr       = 0;
                        reset_hit = 1'b1;
                        break;
                    end
                    tx_busy = (mode != 1) && (k >= d) && (k < d + len);
                end else begin
                    check_eq("ack_vec",   32'(req_ack),   32'(hb));
                    check_eq("ack_err",   32'(req_err),   (mode == 1) ? 32'd1 : 32'd0);
                    check_eq("ack_idle",  32'(arb_busy),  32'd0);
                    check_eq("ack_grant", 32'(grant_id),  32'(w));
                    check_eq("ack_data",  32'(tx_p_data), 32'(exp_data));
                    check_eq("ack_par",   32'(tx_par_en), 32'(exp_par));
                    tx_busy = 1'b0;
                end
            end

            if (reset_hit) begin
                req_valid = 4'($urandom_range(1, 15));
                mask      = 4'd0;
            end else begin
                if (mode != 1) ptr = (w + 1) % NUM_REQ;
                mask = hb;
                if (f < 5) begin
                    req_valid = 4'hF;
                end else if (f == 6) begin
                    req_valid = hb;
                end else if (f == 7 || $urandom_range(0, 7) == 0) begin
                    req_valid = hb;
                    hold_bit  = hb;
                    hold_drop = 1'b1;
                end else begin
                    req_valid = 4'($urandom);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
